// File: rtl/exe_wb_stage.sv
// Execute/writeback stage: single-cycle ALU ops plus an iterative shift-add multiplier.
// Results are registered straight into the register-file write port.
module exe_wb_stage #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] rdata1_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic [2:0]       opcode_in,
    input  logic [ASIZE-1:0] waddr_in,
    output logic             wen_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic [DSIZE-1:0] wdata_out,
    output logic             busy
);

    localparam int SHW = $clog2(DSIZE);
    localparam int CW  = $clog2(DSIZE + 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLL = 3'b100,
        OP_SRL = 3'b101,
        OP_SRA = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [DSIZE-1:0] mcand_q, mplier_q, acc_q;
    logic [ASIZE-1:0] mul_waddr_q;

    logic             accept;
    logic             start_mul;
    logic [SHW-1:0]   shamt;
    logic [DSIZE-1:0] alu_res;
    logic [DSIZE-1:0] mul_step;

    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (opcode_in == OP_MUL);
    assign shamt     = rdata2_in[SHW-1:0];
    // Only the low DSIZE product bits are kept, so the multiplicand may truncate as it shifts.
    assign mul_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_mul) state_d = MUL;
            MUL:     if (cnt_q == CW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q == MUL);
    end

    always_comb begin
        alu_res = '0;
        case (opcode_in)
            OP_ADD:  alu_res = rdata1_in + rdata2_in;
            OP_SUB:  alu_res = rdata1_in - rdata2_in;
            OP_AND:  alu_res = rdata1_in & rdata2_in;
            OP_OR:   alu_res = rdata1_in | rdata2_in;
            OP_SLL:  alu_res = rdata1_in << shamt;
            OP_SRL:  alu_res = rdata1_in >> shamt;
            OP_SRA:  alu_res = $signed(rdata1_in) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            mul_waddr_q <= '0;
            wen_out     <= 1'b0;
            waddr_out   <= '0;
            wdata_out   <= '0;
        end else begin
            wen_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_mul) begin
                        mcand_q     <= rdata1_in;
                        mplier_q    <= rdata2_in;
                        acc_q       <= '0;
                        mul_waddr_q <= waddr_in;
                        cnt_q       <= CW'(DSIZE);
                    end else if (accept) begin
                        wen_out   <= |waddr_in;
                        waddr_out <= waddr_in;
                        wdata_out <= alu_res;
                    end
                end
                MUL: begin
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    acc_q    <= mul_step;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        wen_out   <= |mul_waddr_q;
                        waddr_out <= mul_waddr_q;
                        wdata_out <= mul_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/exe_wb_stage.md
EXE_WB_STAGE -- requirements
Module: exe_wb_stage

Interface
REQ-001 SHALL have parameter DSIZE, default 16, data width.
REQ-002 SHALL have parameter ASIZE, default 5, register-address width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1, the ID/EXE register holds a valid instruction.
REQ-006 SHALL have port in_ready, output, 1, the block accepts an instruction this cycle.
REQ-007 SHALL have port rdata1_in, input, DSIZE, operand A.
REQ-008 SHALL have port rdata2_in, input, DSIZE, operand B.
REQ-009 SHALL have port opcode_in, input, 3, operation select.
REQ-010 SHALL have port waddr_in, input, ASIZE, destination register.
REQ-011 SHALL have port wen_out, output, 1, register-file write enable (registered).
REQ-012 SHALL have port waddr_out, output, ASIZE, register-file write address (registered).
REQ-013 SHALL have port wdata_out, output, DSIZE, register-file write data (registered).
REQ-014 SHALL have port busy, output, 1, a multi-cycle operation is in progress.

Function
REQ-015 SHALL accept an instruction on a rising edge where in_valid=1 and in_ready=1; other edges SHALL ignore the inputs.
REQ-016 SHALL decode opcodes as follows: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 SLL, 101 SRL, 110 SRA, 111 MUL.
REQ-017 SHALL truncate all results to DSIZE bits and SHALL NOT produce carry or overflow flags.
REQ-018 SHALL take the shift amount for opcodes 100-110 from the low log2(DSIZE) bits of B and ignore the upper bits of B.
REQ-019 SHALL register the result of opcodes 000-110 on the accepting edge: wen_out, waddr_out and wdata_out are valid in the following cycle (latency 1), and wen_out is high for exactly one cycle.
REQ-020 SHALL implement a two-state FSM: IDLE and MUL.
REQ-021 SHALL move from IDLE to MUL when it accepts opcode 111, latching A, B and waddr_in and loading the iteration counter with DSIZE.
REQ-022 SHALL perform one shift-add iteration per cycle in MUL (multiplicand shifts left, multiplier shifts right, the accumulator adds the multiplicand when the multiplier LSB is 1) and decrement the counter.
REQ-023 SHALL, on the edge where the counter goes from 1 to 0, register the low DSIZE bits of the product to wdata_out, set wen_out=1, and return to IDLE, so the MUL result appears DSIZE+1 cycles after the accepting edge.
REQ-024 SHALL drive in_ready=1 and busy=0 in IDLE, and in_ready=0 and busy=1 in MUL; both are combinational from the state.
REQ-025 SHALL ignore in_valid, opcode_in and the operands while in MUL; the upstream stage holds the instruction until in_ready=1.
REQ-026 SHALL allow back-to-back acceptance: in the cycle where a MUL result is presented (wen_out=1), in_ready=1 and a new instruction can be accepted.
REQ-027 SHALL force wen_out=0 whenever the destination address is 0, with waddr_out and wdata_out still updated.
REQ-028 SHALL drive wen_out=0 on every edge that neither accepts a single-cycle operation nor completes a MUL; waddr_out and wdata_out SHALL hold their last values.

Reset
REQ-029 SHALL, while rst=0, immediately force state=IDLE, counter=0, wen_out=0, waddr_out=0, wdata_out=0, and all internal operand and accumulator registers to 0, independent of clk.
REQ-030 SHALL abort any MUL in progress on reset with no write issued, and accept a new instruction on the first edge after rst rises.

Verification
REQ-031 SHALL pass: ADD with A=0x7FFF, B=0x0001, waddr=3 -> one cycle later wen_out=1, waddr_out=3, wdata_out=0x8000; SUB with A=0x0000, B=0x0001 -> wdata_out=0xFFFF.
REQ-032 SHALL pass: SRA with A=0x8000, B=0x0013 (shift amount 3) -> wdata_out=0xF000; SRL with the same operands -> wdata_out=0x1000.
REQ-033 SHALL pass: MUL with A=0x0012, B=0x0034, waddr=7 -> in_ready=0 for 16 cycles, then wen_out=1, wdata_out=0x03A8, waddr_out=7; MUL with A=0xFFFF, B=0xFFFF -> wdata_out=0x0001.
REQ-034 SHALL pass: an ADD held on in_valid during a MUL -> not accepted until in_ready=1, then it completes one cycle after the MUL writeback, with no lost or duplicated write.
REQ-035 SHALL pass: rst=0 asserted mid-MUL at iteration 5 -> outputs are 0 immediately, no wen_out pulse occurs, and an ADD issued after reset completes normally.
REQ-036 SHALL pass: OR with A=0x00F0, B=0x000F, waddr=0 -> wen_out stays 0 and wdata_out=0x00FF.
